fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the 16-bit FIFO write port (data_1/data_1_en/buffer_full) between N producers.
//  Round-robin arbitration with a per-grant burst quantum; a grant holds until the owner
//  drops req or BURST beats are written. Sits between producer blocks and the FIFO write side.
//  Whole block is in the FIFO write clock domain.
// PARAMETERS
//  N     4   number of requesters
//  W     16  data width per requester
//  IDW   2   width of owner index, equal to clog2(N)
//  BURST 4   max beats per grant, legal range 1..255
// PORTS
//  clk          in   1    clock, all logic on posedge
//  rst          in   1    synchronous reset, active-low (rst==0 resets)
//  req          in   N    req[i]=1: requester i has a word on its data_in slice
//  data_in      in   N*W  requester i data at [i*W +: W]
//  buffer_full  in   1    FIFO full flag, no write accepted while 1
//  grant        out  N    one-hot registered owner; all-zero when idle
//  active_id    out  IDW  index of current owner, valid when busy=1
//  busy         out  1    1 while a grant is held
//  data_1       out  W    FIFO write data = data_in slice of owner (comb mux); 0 when idle
//  data_1_en    out  1    FIFO write strobe, combinational
//  beat_ack     out  N    one-hot: requester i's word consumed this cycle
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, grant=0, busy=0, active_id=0, beat_cnt=0, last=N-1.
//   Comb outputs during reset: data_1_en=0, beat_ack=0, data_1=0.
//   Reset mid-burst aborts the burst; no beat is issued in the reset cycle.
//  Beat = cycle with busy & req[owner] & !buffer_full. data_1_en=1 and beat_ack[owner]=1 that
//   same cycle, else both 0. A requester must hold data stable until beat_ack.
//  RR pick: first i with req[i]=1, scanning (last+1) mod N upward with wrap. On a grant, last=owner.
//  FSM, 2 states, transitions at posedge:
//   IDLE: if |req, go to OWN with the RR pick; grant registered, so first beat is 1 cycle later.
//         beat_cnt=0. Stay IDLE if req==0.
//   OWN:  on beat, beat_cnt+1 (8-bit, cannot wrap because BURST<=255).
//         Release if beat occurs with beat_cnt==BURST-1, or if req[owner]==0 (no beat that cycle).
//         On release: RR pick among current req, excluding owner's bit only if owner req==0.
//           If the pick is found, stay OWN with the new owner and beat_cnt=0 (no idle gap).
//           Else go IDLE.
//         If owner is the only requester after the quantum expires, it is re-granted immediately.
//  buffer_full=1 in OWN: no beat, beat_cnt frozen, grant held, no release unless req[owner] drops.
//  req changes of non-owners never affect the current grant.
//  Throughput: 1 word/cycle sustained while the owner requests and FIFO is not full.
//  Invariants: grant one-hot or zero; data_1_en implies !buffer_full; busy == |grant.
// TESTING
//  1 Reset: rst=0 for 2 cycles with req=4'b1111 -> grant=0, busy=0, data_1_en=0; release rst
//    -> grant=4'b0001 at the next posedge.
//  2 Single requester: req=4'b0010, data=16'hA001 held, BURST=4 -> grant 0010 one cycle later,
//    data_1_en=1 every cycle, data_1=16'hA001, re-granted without gap after the 4th beat.
//  3 Fairness: req=4'b1111 held -> beat owners 0,0,0,0,1,1,1,1,2...,3...,0, one write per cycle.
//  4 Backpressure: buffer_full=1 for 3 cycles after beat 2 of owner 0 -> data_1_en=0, grant held;
//    then 2 more beats before handoff to 1 (4 total).
//  5 Early release: owner 0 drops req after 2 beats, req[2]=1 -> next cycle grant=4'b0100,
//    beat_cnt restarts at 0.
//  6 Reset mid-burst: rst=0 during owner 3 beat 2 -> grant=0 next edge; after release with
//    req=4'b1000 -> grant 1000, full 4-beat quantum.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares one FIFO write port between N producers. Round-robin arbitration with a per-grant
//   burst quantum: a grant holds until the owner drops req or BURST beats have been written.
//   On release the next owner is picked in the same cycle, so there is no idle gap.
// Ports
//   clk          clock, all state on posedge
//   rst          synchronous reset, active-low
//   req          per-requester "word available" flags
//   data_in      requester i data at [i*W +: W]
//   buffer_full  FIFO full; no write while high
//   grant        registered one-hot owner, zero when idle
//   active_id    owner index, valid while busy
//   busy         a grant is held
//   data_1       FIFO write data (owner slice), zero when idle or in reset
//   data_1_en    FIFO write strobe
//   beat_ack     one-hot: requester's word consumed this cycle
module fifo_write_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned IDW   = 2,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data_in,
  input  logic             buffer_full,
  output logic [N-1:0]     grant,
  output logic [IDW-1:0]   active_id,
  output logic             busy,
  output logic [W-1:0]     data_1,
  output logic             data_1_en,
  output logic [N-1:0]     beat_ack
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;

  logic           own;
  logic           owner_req;
  logic           beat;
  logic           rel;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;

  assign own       = (state_q == StOwn);
  assign owner_req = req[owner_q];
  // Gated by rst so nothing is written in a reset cycle, even mid-burst.
  assign beat      = rst && own && owner_req && !buffer_full;
  assign rel       = (beat && (beat_cnt_q == 8'(BURST - 1))) || (own && !owner_req);

  assign grant     = grant_q;
  assign busy      = own;
  assign active_id = owner_q;
  assign data_1_en = beat;

  always_comb begin
    data_1   = '0;
    beat_ack = '0;
    if (rst && own) begin
      data_1 = data_in[int'(owner_q)*W +: W];
    end
    if (beat) begin
      beat_ack[owner_q] = 1'b1;
    end
  end

  // Round-robin pick: first set req scanning from last+1 with wrap. The owner's own bit is
  // included, so a lone requester is re-granted when its quantum expires; when the owner has
  // dropped req its bit is already zero, so no explicit exclusion is needed.
  always_comb begin : rr_pick
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_q) + i) % N;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    if (!own || rel) begin
      if (pick_found) begin
        state_d    = StOwn;
        grant_d    = pick_onehot;
        owner_d    = pick_idx;
        last_d     = pick_idx;
        beat_cnt_d = '0;
      end else begin
        state_d    = StIdle;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      last_q     <= IDW'(N - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter (N=4, W=16, BURST=4). Inputs change 1 time unit
//   after posedge; outputs are checked at the following negedge.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic        buffer_full;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic        busy;
  logic [15:0] data_1;
  logic        data_1_en;
  logic [3:0]  beat_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_data [4];
  logic [3:0]  one = 4'b0001;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N(4), .W(16), .IDW(2), .BURST(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .buffer_full (buffer_full),
    .grant       (grant),
    .active_id   (active_id),
    .busy        (busy),
    .data_1      (data_1),
    .data_1_en   (data_1_en),
    .beat_ack    (beat_ack)
  );

  // Two reset cycles, then rst released 1 unit after a posedge (cycle "P0").
  task automatic do_reset();
    rst = 1'b0;
    req = 4'b0000;
    buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    buffer_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (data_1_en !== 1'b0 || beat_ack !== 4'b0000 || data_1 !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_comb: got en=%b ack=%b d=%h want 0/0000/0000", data_1_en, beat_ack, data_1);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_p0_grant: got %b want 0000", grant); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || active_id !== 2'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got g=%b id=%0d busy=%b want 0001/0/1", grant, active_id, busy);
    end
    n_checks++;
    if (data_1_en !== 1'b1 || data_1 !== 16'hC000) begin
      n_fail++;
      $display("FAIL reset_first_beat: got en=%b d=%h want 1/c000", data_1_en, data_1);
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || data_1_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: got g=%b en=%b want 0000/0", grant, data_1_en);
    end
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0010 || active_id !== 2'd1 || data_1_en !== 1'b1 ||
          data_1 !== 16'hA001 || beat_ack !== 4'b0010) begin
        n_fail++;
        $display("FAIL single_beat%0d: got g=%b id=%0d en=%b d=%h ack=%b want 0010/1/1/a001/0010",
                 k, grant, active_id, data_1_en, data_1, beat_ack);
      end
    end
  endtask

  task automatic test_fairness();
    int o;
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      next_cycle();
      @(negedge clk);
      o = ((k - 1) / 4) % 4;
      n_checks++;
      if (beat_ack !== (one << o) || grant !== (one << o) || data_1_en !== 1'b1 ||
          data_1 !== exp_data[o]) begin
        n_fail++;
        $display("FAIL fair_cycle%0d: got g=%b ack=%b en=%b d=%h want owner %0d d=%h",
                 k, grant, beat_ack, data_1_en, data_1, o, exp_data[o]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      buffer_full = (k >= 3 && k <= 5);
      @(negedge clk);
      n_checks++;
      if (k >= 3 && k <= 5) begin
        if (data_1_en !== 1'b0 || beat_ack !== 4'b0000 || grant !== 4'b0001) begin
          n_fail++;
          $display("FAIL bp_full%0d: got en=%b ack=%b g=%b want 0/0000/0001",
                   k, data_1_en, beat_ack, grant);
        end
      end else if (k <= 7) begin
        if (data_1_en !== 1'b1 || beat_ack !== 4'b0001 || grant !== 4'b0001) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got en=%b ack=%b g=%b want 1/0001/0001",
                   k, data_1_en, beat_ack, grant);
        end
      end else begin
        if (grant !== 4'b0010 || beat_ack !== 4'b0010) begin
          n_fail++;
          $display("FAIL bp_handoff: got g=%b ack=%b want 0010/0010", grant, beat_ack);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 3) req = 4'b0100;
      if (k == 5) req = 4'b1100;
      @(negedge clk);
      n_checks++;
      if (k <= 2) begin
        if (beat_ack !== 4'b0001) begin
          n_fail++; $display("FAIL early_beat%0d: got ack=%b want 0001", k, beat_ack);
        end
      end else if (k == 3) begin
        if (data_1_en !== 1'b0 || grant !== 4'b0001) begin
          n_fail++; $display("FAIL early_drop: got en=%b g=%b want 0/0001", data_1_en, grant);
        end
      end else if (k <= 7) begin
        if (grant !== 4'b0100 || beat_ack !== 4'b0100 || data_1 !== 16'hB002) begin
          n_fail++;
          $display("FAIL early_new%0d: got g=%b ack=%b d=%h want 0100/0100/b002", k, grant, beat_ack, data_1);
        end
      end else begin
        if (grant !== 4'b1000 || beat_ack !== 4'b1000) begin
          n_fail++; $display("FAIL early_quantum: got g=%b ack=%b want 1000/1000", grant, beat_ack);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1000;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (beat_ack !== 4'b1000) begin n_fail++; $display("FAIL mid_beat1: got ack=%b want 1000", beat_ack); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_1_en !== 1'b0 || beat_ack !== 4'b0000 || data_1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_rst_cycle: got en=%b ack=%b d=%h want 0/0000/0000", data_1_en, beat_ack, data_1);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_aborted: got g=%b busy=%b want 0000/0", grant, busy);
    end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 1) req = 4'b1001;
      @(negedge clk);
      n_checks++;
      if (k <= 4) begin
        if (grant !== 4'b1000 || beat_ack !== 4'b1000 || data_1 !== 16'hD003) begin
          n_fail++;
          $display("FAIL mid_regrant%0d: got g=%b ack=%b d=%h want 1000/1000/d003", k, grant, beat_ack, data_1);
        end
      end else begin
        if (grant !== 4'b0001 || beat_ack !== 4'b0001) begin
          n_fail++; $display("FAIL mid_handoff: got g=%b ack=%b want 0001/0001", grant, beat_ack);
        end
      end
    end
  endtask

  initial begin
    exp_data[0] = 16'hC000;
    exp_data[1] = 16'hA001;
    exp_data[2] = 16'hB002;
    exp_data[3] = 16'hD003;
    data_in = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    rst = 1'b0;
    req = 4'b0000;
    buffer_full = 1'b0;

    test_reset();
    test_single_requester();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
